i2c_cmd_sequencer: RTL and testbench

//  Command queue and sequencer directly upstream of I2C_master. Buffers (slave_addr, data)

---
 rtl/i2c_cmd_sequencer_if.sv | 23 ++
 rtl/i2c_cmd_sequencer.sv | 139 +++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// Host command channel and I2C-master control channel for the command sequencer.
// "master" is the sequencer's view; "slave" is the host/I2C-master side.
interface i2c_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       m_start;
    logic [7:0] m_slave_addr;
    logic [7:0] m_data_in;
    logic       m_done;
    logic       m_nack;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, m_done, m_nack,
        output cmd_ready, m_start, m_slave_addr, m_data_in
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, m_done, m_nack,
        input  cmd_ready, m_start, m_slave_addr, m_data_in
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Write-command queue in front of an I2C master: buffers (addr, data) pairs and issues
// them one at a time, retrying NACKs, aborting on timeout and counting both outcomes.
module i2c_cmd_sequencer #(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    i2c_cmd_sequencer_if.master    bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             nack_drops,
    output logic [7:0]             timeouts
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    retry_q, retry_d;
    logic [7:0]    drops_q, drops_d;
    logic [7:0]    touts_q, touts_d;
    logic [15:0]   fifo_mem [DEPTH];
    logic          ready;
    logic          push;
    logic          pop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign ready = (count_q < CW'(DEPTH));

    always_comb begin
        push     = bus.cmd_valid && ready;
        pop      = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        timer_d = timer_q;
        retry_d = retry_q;
        drops_d = drops_q;
        touts_d = touts_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {addr_d, data_d} = fifo_mem[rd_ptr_q];
                    retry_d          = '0;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // A completion on the expiry cycle takes priority over the timeout.
                if (bus.m_done) begin
                    if (!bus.m_nack) begin
                        state_d = RETIRE;
                    end else if (retry_q < 3'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ISSUE;
                    end else begin
                        drops_d = sat_inc(drops_q);
                        state_d = RETIRE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    touts_d = sat_inc(touts_q);
                    state_d = RETIRE;
                end
            end
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            timer_q  <= '0;
            retry_q  <= '0;
            drops_q  <= '0;
            touts_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            drops_q  <= drops_d;
            touts_q  <= touts_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.cmd_addr, bus.cmd_data};
        end
    end

    assign bus.cmd_ready    = ready;
    assign bus.m_start      = (state_q == ISSUE);
    assign bus.m_slave_addr = addr_q;
    assign bus.m_data_in    = data_q;
    assign busy             = (state_q != IDLE) || (count_q != '0);
    assign fifo_count       = count_q;
    assign nack_drops       = drops_q;
    assign timeouts         = touts_q;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: an event-scheduled model of the command
// queue predicts every output each cycle, plus hand-computed directed expectations.
module tb_i2c_cmd_sequencer;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0]             nack_drops;
    logic [7:0]             timeouts;

    i2c_cmd_sequencer_if bus();

    i2c_cmd_sequencer #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy),
        .fifo_count(fifo_count), .nack_drops(nack_drops), .timeouts(timeouts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- master responder ----------------
    int resp_delay = 1;   // 0 = never answer
    bit resp_nack  = 1'b0;
    int resp_cnt;

    initial begin
        bus.m_done = 1'b0;
        bus.m_nack = 1'b0;
        resp_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_done = 1'b0;
            bus.m_nack = 1'b0;
            if (reset) begin
                resp_cnt = 0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        bus.m_done = 1'b1;
                        bus.m_nack = resp_nack;
                    end
                end
                if (bus.m_start && resp_delay > 0) resp_cnt = resp_delay;
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    logic [15:0] mq[$];
    logic [15:0] issued_log[$];
    bit          mdl_active;
    int          mdl_start_cyc, mdl_idle_from, mdl_tries, mdl_drops, mdl_touts;
    logic [15:0] mdl_cur;
    int          cyc = 0;
    int          start_pulses = 0;
    time         last_start_time, last_done_time, push_time;
    logic [15:0] last_done_cmd;
    bit          e_start, e_busy, push_ok, do_pop;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                mdl_active = 1'b0; mdl_idle_from = 0; mdl_start_cyc = 0;
                mdl_cur = '0; mdl_tries = 0; mdl_drops = 0; mdl_touts = 0;
            end
            e_start = mdl_active && (cyc == mdl_start_cyc);
            e_busy  = mdl_active || (cyc < mdl_idle_from) || (mq.size() != 0);
            chk("m_start",      int'(bus.m_start),      int'(e_start));
            chk("m_slave_addr", int'(bus.m_slave_addr), int'(mdl_cur[15:8]));
            chk("m_data_in",    int'(bus.m_data_in),    int'(mdl_cur[7:0]));
            chk("cmd_ready",    int'(bus.cmd_ready),    int'(mq.size() < DEPTH));
            chk("fifo_count",   int'(fifo_count),       mq.size());
            chk("busy",         int'(busy),             int'(e_busy));
            chk("nack_drops",   int'(nack_drops),       mdl_drops);
            chk("timeouts",     int'(timeouts),         mdl_touts);
            if (!reset) begin
                if (bus.m_start) begin
                    start_pulses++;
                    last_start_time = $time;
                    issued_log.push_back({bus.m_slave_addr, bus.m_data_in});
                end
                if (bus.m_done) begin
                    last_done_time = $time;
                    last_done_cmd  = {bus.m_slave_addr, bus.m_data_in};
                end
                push_ok = bus.cmd_valid && (mq.size() < DEPTH);
                do_pop  = !mdl_active && (cyc >= mdl_idle_from) && (mq.size() != 0);
                if (mdl_active && cyc > mdl_start_cyc) begin
                    if (bus.m_done && !bus.m_nack) begin
                        mdl_active = 1'b0; mdl_idle_from = cyc + 2;
                    end else if (bus.m_done) begin
                        if (mdl_tries < MAX_RETRY) begin
                            mdl_tries++; mdl_start_cyc = cyc + 1;
                        end else begin
                            if (mdl_drops < 255) mdl_drops++;
                            mdl_active = 1'b0; mdl_idle_from = cyc + 2;
                        end
                    end else if (cyc - mdl_start_cyc == TIMEOUT) begin
                        if (mdl_touts < 255) mdl_touts++;
                        mdl_active = 1'b0; mdl_idle_from = cyc + 2;
                    end
                end
                if (do_pop) begin
                    mdl_cur = mq.pop_front();
                    mdl_active = 1'b1; mdl_start_cyc = cyc + 1; mdl_tries = 0;
                end
                if (push_ok) mq.push_back({bus.cmd_addr, bus.cmd_data});
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        int n;
        bit took;
        n = 0; took = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_data = d;
        while (!took) begin
            @(negedge clk);
            took = bus.cmd_ready;
            if (took) push_time = $time;
            @(posedge clk); #1;
            n++;
            if (!took && n >= 400) begin
                n_checks++; n_errors++;
                $display("FAIL push_wait: cmd_ready stayed 0 for %0d cycles (addr %02h), required 1", n, a);
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        $display("push addr=%02h data=%02h accepted=%0d", a, d, took);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n >= limit) begin
                n_checks++; n_errors++;
                $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Waits until the selected counter (0 = nack_drops, 1 = timeouts) reaches target.
    task automatic wait_counter(input int sel, input int target, input int limit, output time seen);
        int n;
        n = 0; seen = 0;
        forever begin
            @(negedge clk);
            if ((sel == 0 ? int'(nack_drops) : int'(timeouts)) >= target) begin
                seen = $time;
                break;
            end
            n++;
            if (n >= limit) begin
                n_checks++; n_errors++;
                $display("FAIL wait_counter%0d: target %0d not reached in %0d cycles", sel, target, n);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        $display("reset pulse applied");
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int  p0;
        time seen;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_m_start", int'(bus.m_start), 0);
        @(posedge clk); #1;

        // 1: single command, ack after TIMEOUT-4 cycles
        resp_delay = TIMEOUT - 4; resp_nack = 1'b0;
        p0 = start_pulses;
        push(8'h50, 8'hA5);
        wait_idle(100);
        chk("t1_pulses", start_pulses - p0, 1);
        chk("t1_latency", int'((last_start_time - push_time) / 10), 2);
        chk("t1_done_cmd", int'(last_done_cmd), 16'h50A5);
        chk("t1_drops", int'(nack_drops), 0);
        chk("t1_touts", int'(timeouts), 0);
        $display("test1 single command done");

        // 2: queue fills while master is stalled on an earlier command
        resp_delay = TIMEOUT - 2;
        p0 = start_pulses;
        push(8'h10, 8'h00);
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i), 8'hC0 + 8'(i));
        bus.cmd_valid = 1'b1; bus.cmd_addr = 8'h15; bus.cmd_data = 8'hC4;
        @(negedge clk);
        chk("t2_full_count", int'(fifo_count), 4);
        chk("t2_full_ready", int'(bus.cmd_ready), 0);
        @(posedge clk); #1;
        push(8'h15, 8'hC4);
        wait_idle(400);
        chk("t2_pulses", start_pulses - p0, 6);
        for (int i = 0; i < 5; i++)
            chk("t2_order", int'(issued_log[issued_log.size() - 5 + i]),
                int'({8'h11 + 8'(i), 8'hC0 + 8'(i)}));
        $display("test2 full queue done");

        // 3: NACK on every try, then the next command succeeds
        resp_delay = 1; resp_nack = 1'b1;
        p0 = start_pulses;
        push(8'h2A, 8'h01);
        push(8'h2B, 8'h02);
        wait_counter(0, 1, 100, seen);
        chk("t3_pulses_at_drop", start_pulses - p0, 3);
        resp_nack = 1'b0;
        wait_idle(100);
        chk("t3_pulses", start_pulses - p0, 4);
        chk("t3_drops", int'(nack_drops), 1);
        chk("t3_next_cmd", int'(last_done_cmd), 16'h2B02);
        $display("test3 nack retry done");

        // 4a: no m_done ever -> abort; counter visible one cycle after the 16th WAIT cycle
        do_reset();
        resp_delay = 0;
        push(8'h3C, 8'h03);
        wait_counter(1, 1, 100, seen);
        chk("t4_abort_delay", int'((seen - last_start_time) / 10), 17);
        wait_idle(50);
        chk("t4_touts", int'(timeouts), 1);
        // 4b: m_done on the expiry cycle counts as success
        do_reset();
        resp_delay = TIMEOUT;
        push(8'h3D, 8'h04);
        wait_idle(100);
        chk("t4b_done_delay", int'((last_done_time - last_start_time) / 10), 16);
        chk("t4b_touts", int'(timeouts), 0);
        $display("test4 timeout done");

        // 5: reset during WAIT with 3 commands queued
        resp_delay = 0;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 8'h00);
        #1 reset = 1'b1;
        #1;
        chk("t5_m_start", int'(bus.m_start), 0);
        chk("t5_ready", int'(bus.cmd_ready), 1);
        chk("t5_count", int'(fifo_count), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_addr", int'(bus.m_slave_addr), 0);
        @(posedge clk); #1 reset = 1'b0;
        p0 = start_pulses;
        step(40);
        chk("t5_no_start", start_pulses - p0, 0);
        resp_delay = 2;
        push(8'h5E, 8'h55);
        wait_idle(50);
        chk("t5_new_start", start_pulses - p0, 1);
        $display("test5 reset mid-transfer done");

        // 6: 256 timeouts saturate the counter
        do_reset();
        resp_delay = 0;
        for (int i = 0; i < 256; i++) push(8'h80, 8'(i));
        wait_idle(400);
        chk("t6_touts_sat", int'(timeouts), 255);
        $display("test6 saturation done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
